// File: rtl/btn_debounce_pulse_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | btn_debounce_pulse_if : raw button in, debounced level/pulses out  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface btn_debounce_pulse_if;
  logic btn_raw;
  logic btn_level;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;

  modport master (
    output btn_raw,
    input  btn_level,
    input  rise_pulse,
    input  fall_pulse,
    input  busy
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output rise_pulse,
    output fall_pulse,
    output busy
  );
endinterface
`default_nettype wire

// File: rtl/btn_debounce_pulse.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | btn_debounce_pulse : sync + debounce FSM + edge pulses; optional   |
// | auto-repeat on a held button via `BTN_AUTOREPEAT_EN. Revision 1.0  |
// +--------------------------------------------------------------------+
module btn_debounce_pulse #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 4
) (
  input wire logic            clk,
  input wire logic            rst,
  btn_debounce_pulse_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Out-of-range parameters stop elaboration instead of building a broken counter.
  if ((DEBOUNCE_CYCLES < 2) ||
      ((CNT_W < 31) && (DEBOUNCE_CYCLES >= (1 << CNT_W))) ||
      (REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_bad_params
    $error("btn_debounce_pulse: illegal parameter combination");
  end

  logic             sync_ff1;
  logic             sync_ff2;
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             level;
  logic             level_next;
  logic             rise;
  logic             rise_next;
  logic             fall;
  logic             fall_next;
  logic             in_wait;
  logic             in_wait_next;

`ifdef BTN_AUTOREPEAT_EN
  logic [CNT_W-1:0] rep_cnt;
  logic [CNT_W-1:0] rep_cnt_next;
  logic [CNT_W-1:0] rep_inc;
  logic             rep_armed;
  logic             rep_armed_next;

  assign rep_inc = rep_cnt + CNT_ONE;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff1 <= 1'b0;
      sync_ff2 <= 1'b0;
    end else begin
      sync_ff1 <= bus.btn_raw;
      sync_ff2 <= sync_ff1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE_LOW;
      cnt     <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      in_wait <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      level   <= level_next;
      rise    <= rise_next;
      fall    <= fall_next;
      in_wait <= in_wait_next;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end else begin
      rep_cnt   <= rep_cnt_next;
      rep_armed <= rep_armed_next;
    end
  end
`endif

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    level_next = level;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    // Anything other than staying in IDLE_HIGH clears the repeat timer.
    rep_cnt_next   = '0;
    rep_armed_next = 1'b0;
`endif

    case (state)
      IDLE_LOW: begin
        if (sync_ff2) begin
          state_next = WAIT_HIGH;
          cnt_next   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!sync_ff2) begin
          state_next = IDLE_LOW;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE_HIGH;
          cnt_next   = '0;
          level_next = 1'b1;
          rise_next  = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!sync_ff2) begin
          state_next = WAIT_LOW;
          cnt_next   = CNT_ONE;
        end
`ifdef BTN_AUTOREPEAT_EN
        else begin
          // First repeat after REPEAT_DELAY, then every REPEAT_PERIOD.
          rep_armed_next = rep_armed;
          rep_cnt_next   = rep_inc;
          if ((!rep_armed && (rep_inc == CNT_W'(REPEAT_DELAY))) ||
              ( rep_armed && (rep_inc == CNT_W'(REPEAT_PERIOD)))) begin
            rise_next      = 1'b1;
            rep_cnt_next   = '0;
            rep_armed_next = 1'b1;
          end
        end
`endif
      end
      WAIT_LOW: begin
        if (sync_ff2) begin
          state_next = IDLE_HIGH;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE_LOW;
          cnt_next   = '0;
          level_next = 1'b0;
          fall_next  = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE_LOW;
        cnt_next   = '0;
      end
    endcase

    in_wait_next = (state_next == WAIT_HIGH) || (state_next == WAIT_LOW);
  end

  assign bus.btn_level  = level;
  assign bus.rise_pulse = rise;
  assign bus.fall_pulse = fall;
  assign bus.busy       = in_wait;

endmodule
`default_nettype wire

// File: doc/btn_debounce_pulse.md
Name: btn_debounce_pulse

Overview:
- Conditions a raw, asynchronous, bouncy push-button or switch input into a clean one-clock pulse.
- Sits directly upstream of the 4-state press-counting FSM, which expects exactly one `x` pulse per physical press.
- Provides:
  - 2-FF synchroniser;
  - consecutive-sample debounce FSM;
  - registered stable level;
  - rise and fall edge pulses.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronised samples required to accept a new level; legal range 2..(2^CNT_W - 1).
- CNT_W, 16, width of the debounce counter.
- REPEAT_DELAY, 8, cycles held high before the first auto-repeat pulse (used only with the optional feature).
- REPEAT_PERIOD, 4, cycles between subsequent auto-repeat pulses (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- btn_raw  input  1  raw asynchronous button/switch level.
- btn_level  output  1  debounced, registered level.
- rise_pulse  output  1  one-cycle pulse on accepted 0->1; feeds the downstream FSM's `x`.
- fall_pulse  output  1  one-cycle pulse on accepted 1->0.
- busy  output  1  high while a transition is being qualified (WAIT_HIGH or WAIT_LOW).

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset: sync_ff1=0, sync_ff2=0, state=IDLE_LOW, cnt=0, btn_level=0, rise_pulse=0, fall_pulse=0, busy=0.
- All outputs are registered; no combinational path from btn_raw to any output.
- Synchroniser: btn_raw -> sync_ff1 -> sync_ff2 (s). The FSM uses only s.
- FSM states and transitions:
  - IDLE_LOW: if s=1, go to WAIT_HIGH with cnt=1; else stay.
  - WAIT_HIGH:
    - if s=0, go to IDLE_LOW with cnt=0 (bounce rejected, no pulse);
    - else if cnt==DEBOUNCE_CYCLES-1, go to IDLE_HIGH, cnt=0, btn_level<=1, rise_pulse<=1;
    - else cnt<=cnt+1.
  - IDLE_HIGH: if s=0, go to WAIT_LOW with cnt=1; else stay.
  - WAIT_LOW: mirror of WAIT_HIGH.
    - On reaching DEBOUNCE_CYCLES: go to IDLE_LOW, btn_level<=0, fall_pulse<=1.
    - If s=1 before that: return to IDLE_HIGH, no pulse.
  - Illegal/unused encodings go to IDLE_LOW with cnt=0; outputs are not pulsed.
- Pulse width:
  - rise_pulse and fall_pulse are high for exactly one cycle, then return to 0.
  - They are never high in the same cycle.
- Latency: with btn_raw stable high ahead of edge E0, btn_level and rise_pulse go high after edge E0+DEBOUNCE_CYCLES+1.
  - Example, DEBOUNCE_CYCLES=4: high after the 6th edge, counting E0 as the 1st.
  - Falling edge latency is identical.
- busy=1 exactly while state is WAIT_HIGH or WAIT_LOW (registered alongside the state).
- Counter: cnt never exceeds DEBOUNCE_CYCLES-1; no wrap is possible within the legal parameter range.
- Reset mid-qualification: everything returns to reset values at once.
  - A pulse in flight is cleared immediately.
  - After reset is released, a still-held button is re-qualified from IDLE_LOW and produces a fresh rise_pulse.
- Glitch rejection: a bounce shorter than DEBOUNCE_CYCLES synchronised samples produces no pulse and leaves btn_level unchanged.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - While in IDLE_HIGH, a repeat counter runs; it is cleared on entering IDLE_HIGH.
  - An extra one-cycle rise_pulse fires when the counter reaches REPEAT_DELAY, then every REPEAT_PERIOD cycles thereafter.
  - Leaving IDLE_HIGH (to WAIT_LOW) freezes and clears the repeat counter.
  - A bounce that returns to IDLE_HIGH restarts REPEAT_DELAY.
  - btn_level is unaffected.
- Undefined:
  - No repeat logic is synthesised.
  - Exactly one rise_pulse per accepted press; REPEAT_* parameters are ignored.

Test Plan:
- Reset check: rst=1 with btn_raw=1 -> all outputs 0. Release rst with btn_raw held at 1 -> rise_pulse high for 1 cycle after edge 5 (DEBOUNCE_CYCLES=4); btn_level=1 from then on.
- Clean press/release: btn_raw 0->1, held 10 cycles, then 1->0 -> one rise_pulse at edge +5; btn_level high; one fall_pulse 5 edges after the release; busy high during each qualification window.
- Bounce rejection: btn_raw toggles 1,0,1,0,1 (1-cycle each), then held 1 -> no pulse during the bounce; exactly one rise_pulse once s has been 1 for 4 consecutive samples.
- Short glitch: a 2-cycle high blip on btn_raw -> rise_pulse, fall_pulse and btn_level all stay 0; busy briefly 1.
- Reset mid-operation: assert rst while in WAIT_HIGH with cnt=2 -> outputs 0 immediately; after release, with the button still held, a new rise_pulse arrives 5 edges later.
- Downstream integration, BTN_AUTOREPEAT_EN undefined: four clean presses -> exactly 4 rise_pulses; downstream out=1 after the 3rd and returns to 0 after the 4th.
  - With BTN_AUTOREPEAT_EN defined, REPEAT_DELAY=8, REPEAT_PERIOD=4, held 20 cycles: pulses at acceptance, +8, +12, +16, +20.
